alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous active-high reset.
REQ-003 SHALL have: in_valid  in  1 / in_ready  out  1  decode-side handshake.
REQ-004 SHALL have: inst  in  32  RV32I instruction; pc  in  32; rs1_data, rs2_data  in  32 each.
REQ-005 SHALL have: flush  in  1  discard all held entries (branch taken upstream).
REQ-006 SHALL have: out_valid  out  1 / out_ready  in  1  execute-side handshake.
REQ-007 SHALL have: alu_a, alu_b  out  32; alu_mode  out  4; rd  out  5; wb_en, is_branch, is_jump, illegal  out  1 each.

Function
REQ-008 SHALL transfer input when in_valid&&in_ready, output when out_valid&&out_ready.
REQ-009 SHALL decode alu_mode: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLTU/BLTU 1000, BGEU 1001, BNE 1011, SLT/BLT 1100, BGE 1101, BEQ 0001.
REQ-010 SHALL select funct7[5]=1 as SUB for OP and SRA for OP/OP-IMM shifts; ADDI never SUB.
REQ-011 SHALL drive operands: OP a=rs1,b=rs2; OP-IMM/LOAD/JALR-target a=rs1,b=sign-extended imm; STORE b=S-imm; LUI a=0,b=U-imm; AUIPC a=pc,b=U-imm; JAL/JALR a=pc,b=4 (link value).
REQ-012 SHALL zero-extend shift amounts to 32 bits using only bits [4:0] (imm or rs2).
REQ-013 SHALL set is_branch for BRANCH, is_jump for JAL/JALR, wb_en for OP/OP-IMM/LOAD/LUI/AUIPC/JAL/JALR only; rd forced 0 when wb_en=0.
REQ-014 SHALL flag illegal for unknown opcode/funct3/funct7 combos (incl. funct3 010/011 on BRANCH); illegal entry carries alu_mode 0000, wb_en 0, is_branch 0, is_jump 0.
REQ-015 SHALL register outputs: one-cycle latency from accepted input to out_valid.
REQ-016 SHALL drive in_ready = !out_valid || out_ready (baseline); hold outputs stable while out_valid&&!out_ready.
REQ-017 SHALL on flush clear all valid state next edge; flush outranks simultaneous capture (input accepted that cycle is dropped).
REQ-018 SHALL keep bubble throughput 1/cycle under continuous out_ready=1.

Reset
REQ-019 SHALL on rst clear out_valid, all data outputs to 0, skid state empty; in_ready=0 while rst=1.
REQ-020 SHALL abandon any in-flight entry when rst asserts mid-stall.

Configuration
REQ-021 SHALL with ALU_ISSUE_SKID_EN defined add a one-entry skid buffer: in_ready registered (= skid empty), capacity 2 entries, no combinational path out_ready->in_ready.
REQ-022 SHALL without ALU_ISSUE_SKID_EN implement the single-register stage of REQ-016.
REQ-023 SHALL preserve order and flush/reset semantics identically in both builds.

Structure
REQ-024 SHALL take 4-bit mode constants, opcode constants, and entry struct typedef from shared package alu_pkg.
REQ-025 SHALL place combinational decode in sub-module alu_mode_dec (inst, pc, rs1_data, rs2_data -> entry).

Verification
REQ-026 SHALL check: sub x3,x1,x2 (rs1=10,rs2=3) -> alu_mode 0001, a=10, b=3, rd=3, wb_en=1 one cycle later.
REQ-027 SHALL check: srai x5,x6,4 (inst 0x40435293) -> mode 0111, b=4; slli with imm bit5 set -> illegal=1.
REQ-028 SHALL check: bltu then bge -> modes 1000, 1101, is_branch=1, wb_en=0, rd=0.
REQ-029 SHALL check: out_ready=0 for 3 cycles with 2 inputs offered -> outputs stable, no loss/duplication, order preserved (both builds).
REQ-030 SHALL check: flush with in_valid=1 and full stage -> out_valid=0 next cycle, dropped instruction never appears.
REQ-031 SHALL check: rst asserted mid-stall -> out_valid=0, outputs 0, in_ready=0 during reset, 1 the cycle after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU mode/opcode constants, issue entry type and the ALU funct3 mapping.
package alu_pkg;

  localparam logic [3:0] MODE_ADD  = 4'b0000;
  localparam logic [3:0] MODE_SUB  = 4'b0001;
  localparam logic [3:0] MODE_AND  = 4'b0010;
  localparam logic [3:0] MODE_OR   = 4'b0011;
  localparam logic [3:0] MODE_XOR  = 4'b0100;
  localparam logic [3:0] MODE_SLL  = 4'b0101;
  localparam logic [3:0] MODE_SRL  = 4'b0110;
  localparam logic [3:0] MODE_SRA  = 4'b0111;
  localparam logic [3:0] MODE_SLTU = 4'b1000;
  localparam logic [3:0] MODE_BGEU = 4'b1001;
  localparam logic [3:0] MODE_BNE  = 4'b1011;
  localparam logic [3:0] MODE_SLT  = 4'b1100;
  localparam logic [3:0] MODE_BGE  = 4'b1101;
  localparam logic [3:0] MODE_BEQ  = 4'b0001;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_mode;
    logic [4:0]  rd;
    logic        wb_en;
    logic        is_branch;
    logic        is_jump;
    logic        illegal;
  } entry_t;

  // alt selects SUB (funct3 000) or SRA (funct3 101); ignored elsewhere
  function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? MODE_SUB : MODE_ADD;
      3'b001:  return MODE_SLL;
      3'b010:  return MODE_SLT;
      3'b011:  return MODE_SLTU;
      3'b100:  return MODE_XOR;
      3'b101:  return alt ? MODE_SRA : MODE_SRL;
      3'b110:  return MODE_OR;
      default: return MODE_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_mode_dec.sv
// Combinational RV32I decode into an issue entry: ALU mode, operands, rd and flags.
module alu_mode_dec
  import alu_pkg::*;
(
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output entry_t      ent
);

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_u, shamt_i, shamt_r;
  logic        bad, is_shift;

  assign opc      = inst[6:0];
  assign f3       = inst[14:12];
  assign f7       = inst[31:25];
  assign imm_i    = {{20{inst[31]}}, inst[31:20]};
  assign imm_s    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_u    = {inst[31:12], 12'b0};
  assign shamt_i  = {27'b0, inst[24:20]};
  assign shamt_r  = {27'b0, rs2_data[4:0]};
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  always_comb begin
    ent    = '0;
    bad    = 1'b0;
    ent.rd = inst[11:7];
    case (opc)
      OPC_OP: begin
        ent.alu_a    = rs1_data;
        ent.alu_b    = is_shift ? shamt_r : rs2_data;
        ent.alu_mode = alu_fn(f3, f7[5]);
        ent.wb_en    = 1'b1;
        bad = !((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      OPC_OPIMM: begin
        // ADDI carries no funct7, so alt only applies to the right shift
        ent.alu_a    = rs1_data;
        ent.alu_b    = is_shift ? shamt_i : imm_i;
        ent.alu_mode = alu_fn(f3, f3 == 3'b101 && f7[5]);
        ent.wb_en    = 1'b1;
        bad = (f3 == 3'b001 && f7 != 7'h00) ||
              (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
      end
      OPC_LOAD: begin
        ent.alu_a = rs1_data;
        ent.alu_b = imm_i;
        ent.wb_en = 1'b1;
        bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        ent.alu_a = rs1_data;
        ent.alu_b = imm_s;
        bad = (f3 > 3'b010);
      end
      OPC_BRANCH: begin
        ent.alu_a     = rs1_data;
        ent.alu_b     = rs2_data;
        ent.is_branch = 1'b1;
        case (f3)
          3'b000:  ent.alu_mode = MODE_BEQ;
          3'b001:  ent.alu_mode = MODE_BNE;
          3'b100:  ent.alu_mode = MODE_SLT;
          3'b101:  ent.alu_mode = MODE_BGE;
          3'b110:  ent.alu_mode = MODE_SLTU;
          3'b111:  ent.alu_mode = MODE_BGEU;
          default: bad = 1'b1;
        endcase
      end
      OPC_JAL, OPC_JALR: begin
        // ALU produces the link value; target is formed elsewhere
        ent.alu_a   = pc;
        ent.alu_b   = 32'd4;
        ent.wb_en   = 1'b1;
        ent.is_jump = 1'b1;
        bad = (opc == OPC_JALR) && (f3 != 3'b000);
      end
      OPC_LUI: begin
        ent.alu_b = imm_u;
        ent.wb_en = 1'b1;
      end
      OPC_AUIPC: begin
        ent.alu_a = pc;
        ent.alu_b = imm_u;
        ent.wb_en = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      ent         = '0;
      ent.illegal = 1'b1;
    end
    if (!ent.wb_en) ent.rd = '0;
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decode plus one registered output stage.
// Define ALU_ISSUE_SKID_EN for a one-entry skid buffer with registered in_ready.
module alu_issue
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_mode,
  output logic [4:0]  rd,
  output logic        wb_en,
  output logic        is_branch,
  output logic        is_jump,
  output logic        illegal
);

  entry_t dec, q;
  logic   vld_q, take;

  alu_mode_dec u_dec (
    .inst     (inst),
    .pc       (pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .ent      (dec)
  );

  // flush drops whatever is offered in the same cycle
  assign take = in_valid && in_ready && !flush;

`ifdef ALU_ISSUE_SKID_EN
  entry_t skid_q;
  logic   skid_vld;

  // depends only on state and reset, never on out_ready
  assign in_ready = !rst && !skid_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= '0;
      vld_q    <= 1'b0;
      skid_q   <= '0;
      skid_vld <= 1'b0;
    end else if (flush) begin
      vld_q    <= 1'b0;
      skid_vld <= 1'b0;
    end else if (!vld_q || out_ready) begin
      if (skid_vld) begin
        q        <= skid_q;
        vld_q    <= 1'b1;
        skid_vld <= 1'b0;
      end else begin
        vld_q <= take;
        if (take) q <= dec;
      end
    end else if (take) begin
      skid_q   <= dec;
      skid_vld <= 1'b1;
    end
  end
`else
  assign in_ready = !rst && (!vld_q || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      vld_q <= 1'b0;
    end else if (flush) begin
      vld_q <= 1'b0;
    end else if (!vld_q || out_ready) begin
      vld_q <= take;
      if (take) q <= dec;
    end
  end
`endif

  assign out_valid = vld_q;
  assign alu_a     = q.alu_a;
  assign alu_b     = q.alu_b;
  assign alu_mode  = q.alu_mode;
  assign rd        = q.rd;
  assign wb_en     = q.wb_en;
  assign is_branch = q.is_branch;
  assign is_jump   = q.is_jump;
  assign illegal   = q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios plus randomized traffic
// against a queue-based reference model built from the ISA rules.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] inst, pc, rs1_data, rs2_data, alu_a, alu_b;
  logic [3:0]  alu_mode;
  logic [4:0]  rd;
  logic        wb_en, is_branch, is_jump, illegal;
  logic [76:0] obs;

  int passed = 0;
  int total  = 0;
  logic [76:0] expq[$];
  logic [76:0] held;
  logic        hold_pend = 1'b0;
  logic        acc_last  = 1'b0;

  // funct3 -> ALU mode, and funct3 -> branch mode (-1 = reserved)
  int alu_tab[8] = '{0, 5, 12, 8, 4, 6, 3, 2};
  int br_tab[8]  = '{1, 11, -1, -1, 12, 13, 8, 9};
  logic [6:0] opc_tab[10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                              7'h6f, 7'h67, 7'h37, 7'h17, 7'h13};

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .rd(rd),
    .wb_en(wb_en), .is_branch(is_branch), .is_jump(is_jump), .illegal(illegal)
  );

  assign obs = {alu_a, alu_b, alu_mode, rd, wb_en, is_branch, is_jump, illegal};

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [76:0] o, input logic [76:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, o, e);
  endtask

  // Expected packed output {a,b,mode,rd,wb,br,jp,ill} for one instruction
  function automatic logic [76:0] model(input logic [31:0] i, p, r1, r2);
    int          f3 = int'(i[14:12]);
    logic [6:0]  f7 = i[31:25];
    logic [31:0] ii = {{20{i[31]}}, i[31:20]};
    logic [31:0] a = 0, b = 0;
    logic [3:0]  m = 0;
    logic        wb = 0, br = 0, jp = 0, ok = 1;
    case (i[6:0])
      7'h33: begin
        a = r1; b = (f3 == 1 || f3 == 5) ? (r2 & 32'h1f) : r2; wb = 1;
        ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        m = 4'(alu_tab[f3] + ((f7 == 7'h20) ? 1 : 0));
      end
      7'h13: begin
        a = r1; b = (f3 == 1 || f3 == 5) ? {27'b0, i[24:20]} : ii; wb = 1;
        ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1;
        m = 4'(alu_tab[f3] + ((f3 == 5 && f7 == 7'h20) ? 1 : 0));
      end
      7'h03: begin a = r1; b = ii; wb = 1; ok = (f3 inside {0, 1, 2, 4, 5}); end
      7'h23: begin a = r1; b = {{20{i[31]}}, i[31:25], i[11:7]}; ok = (f3 < 3); end
      7'h63: begin a = r1; b = r2; br = 1; ok = (br_tab[f3] >= 0); m = 4'(br_tab[f3]); end
      7'h6f: begin a = p; b = 4; wb = 1; jp = 1; end
      7'h67: begin a = p; b = 4; wb = 1; jp = 1; ok = (f3 == 0); end
      7'h37: begin b = {i[31:12], 12'b0}; wb = 1; end
      7'h17: begin a = p; b = {i[31:12], 12'b0}; wb = 1; end
      default: ok = 0;
    endcase
    if (!ok) return 77'd1;
    return {a, b, m, (wb ? i[11:7] : 5'd0), wb, br, jp, 1'b0};
  endfunction

  function automatic logic [31:0] rnd_inst();
    logic [31:0] x = $urandom;
    int k = $urandom_range(0, 10);
    if (k < 10) x[6:0] = opc_tab[k];
    case ($urandom_range(0, 3))
      0: x[31:25] = 7'h00;
      1: x[31:25] = 7'h20;
      default: ;
    endcase
    return x;
  endfunction

  // One clock: observe at negedge, score handshakes, return 1ns after posedge
  task automatic tick();
    logic [76:0] e;
    @(negedge clk);
    acc_last = 1'b0;
    if (rst) begin
      chk("rst_in_ready", in_ready, 0);
      expq.delete();
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", obs, held);
      end
`ifndef ALU_ISSUE_SKID_EN
      chk("in_ready", in_ready, !out_valid || out_ready);
`endif
      if (out_valid && out_ready) begin
        if (expq.size() == 0) chk("spurious_out", out_valid, 0);
        else begin
          e = expq.pop_front();
          chk("out_entry", obs, e);
        end
      end
      if (in_valid && in_ready && !flush) begin
        expq.push_back(model(inst, pc, rs1_data, rs2_data));
        acc_last = 1'b1;
      end
      if (flush) expq.delete();
      hold_pend = out_valid && !out_ready && !flush;
      held = obs;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] i);
    in_valid = 1'b1; inst = i;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    for (int k = 0; k < 10 && (expq.size() != 0 || out_valid); k++) tick();
    chk("drain_empty", expq.size(), 0);
  endtask

  initial begin
    int idx;
    logic [31:0] pair[2];
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    inst = '0; pc = 32'h100; rs1_data = '0; rs2_data = '0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", obs, 0);
    rst = 1'b0; #1;
    chk("post_rst_in_ready", in_ready, 1);

    // sub x3,x1,x2
    out_ready = 1'b1; rs1_data = 32'd10; rs2_data = 32'd3;
    send(32'h402081B3);
    chk("sub_valid", out_valid, 1);
    chk("sub_mode", alu_mode, 4'b0001);
    chk("sub_a", alu_a, 32'd10);
    chk("sub_b", alu_b, 32'd3);
    chk("sub_rd", rd, 5'd3);
    chk("sub_wb", wb_en, 1);

    // srai x5,x6,4 then slli with shamt bit5 set
    rs1_data = 32'h8000_0000;
    send(32'h40435293);
    chk("srai_mode", alu_mode, 4'b0111);
    chk("srai_b", alu_b, 32'd4);
    send(32'h02031293);
    chk("slli_bad_illegal", illegal, 1);
    chk("slli_bad_flags", {alu_mode, wb_en, is_branch, is_jump, rd}, 0);

    // bltu then bge
    rs1_data = 32'd1; rs2_data = 32'd2;
    send(32'h00216463);
    chk("bltu_mode", alu_mode, 4'b1000);
    chk("bltu_flags", {is_branch, wb_en, rd}, {1'b1, 1'b0, 5'd0});
    send(32'h00215463);
    chk("bge_mode", alu_mode, 4'b1101);
    chk("bge_flags", {is_branch, wb_en, rd}, {1'b1, 1'b0, 5'd0});
    drain();

    // stall for 3 cycles with two instructions offered
    pair[0] = 32'h00500093; pair[1] = 32'h00A00113;
    out_ready = 1'b0; idx = 0;
    for (int k = 0; k < 3; k++) begin
      in_valid = (idx < 2); inst = pair[idx < 2 ? idx : 1];
      tick();
      if (acc_last) idx++;
    end
`ifdef ALU_ISSUE_SKID_EN
    chk("stall_accepts", idx, 2);
`else
    chk("stall_accepts", idx, 1);
`endif
    out_ready = 1'b1;
    for (int k = 0; k < 20 && (idx < 2 || expq.size() != 0); k++) begin
      in_valid = (idx < 2); inst = pair[idx < 2 ? idx : 1];
      tick();
      if (acc_last) idx++;
    end
    in_valid = 1'b0;
    chk("stall_all_sent", idx, 2);
    chk("stall_all_out", expq.size(), 0);
    drain();

    // flush with full stage and a new instruction offered
    out_ready = 1'b0;
    send(32'h00100193);
    send(32'h00200213);
    in_valid = 1'b1; inst = 32'h7FF00393; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("flush_no_leak", out_valid, 0);

    // reset asserted mid-stall
    out_ready = 1'b0;
    send(32'h00300293);
    send(32'h00400313);
    rst = 1'b1; in_valid = 1'b1; inst = 32'h00500393;
    tick();
    chk("rst_stall_valid", out_valid, 0);
    chk("rst_stall_outputs", obs, 0);
    chk("rst_stall_in_ready", in_ready, 0);
    tick();
    rst = 1'b0; in_valid = 1'b0; #1;
    chk("rst_release_in_ready", in_ready, 1);
    chk("rst_release_valid", out_valid, 0);

    // randomized traffic
    for (int k = 0; k < 500; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 39) == 0);
      inst      = rnd_inst();
      pc        = $urandom & 32'hffff_fffc;
      rs1_data  = $urandom;
      rs2_data  = $urandom;
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
